// File: rtl/vdu_writer.sv
// vdu_writer: CPU-side write controller for the VDU-80 character/attribute video RAMs.
// Define VDU_CLEAR_EN to build the hardware clear-screen engine and its one-entry pending-write buffer.
module vdu_writer #(
    parameter logic [7:0] PORT_BASE  = 8'hC0,
    parameter logic [7:0] BLANK_CHAR = 8'h20
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_io_wr,
    input  logic [7:0]  i_io_addr,
    input  logic [7:0]  i_io_data,
    input  logic        i_mem_wr,
    input  logic [11:0] i_mem_addr,
    input  logic [7:0]  i_mem_data,
    output logic        o_wait,
    output logic        o_busy,
    output logic        o_char_we,
    output logic        o_attr_we,
    output logic [10:0] o_vram_addr,
    output logic [7:0]  o_char_data,
    output logic [7:0]  o_attr_data,
    output logic        o_mode80,
    output logic [4:0]  o_counter,
    output logic        o_counter_valid
);

    localparam logic [7:0] PORT_CTRL   = PORT_BASE;
    localparam logic [7:0] PORT_SCROLL = PORT_BASE + 8'd1;

    logic sel_ctrl;
    logic sel_scroll;

    assign sel_ctrl   = i_io_wr && (i_io_addr == PORT_CTRL);
    assign sel_scroll = i_io_wr && (i_io_addr == PORT_SCROLL);

    // Display-stage control registers are live in every state, including during a clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mode80        <= 1'b0;
            o_counter       <= '0;
            o_counter_valid <= 1'b0;
        end else begin
            o_counter_valid <= 1'b0;
            if (sel_ctrl) begin
                o_mode80 <= i_io_data[0];
            end
            if (sel_scroll && (i_io_data < 8'd24)) begin
                o_counter       <= i_io_data[4:0];
                o_counter_valid <= 1'b1;
            end
        end
    end

`ifdef VDU_CLEAR_EN
    localparam logic [7:0] PORT_FILL = PORT_BASE + 8'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_FLUSH
    } state_t;

    state_t      state;
    logic [7:0]  fill_attr;
    logic        pend_plane;
    logic [10:0] pend_addr;
    logic [7:0]  pend_data;
    logic        clear_start;
    logic        capture;
    logic        unused_io;

    assign clear_start = sel_ctrl && i_io_data[7] && (state == ST_IDLE);
    // o_wait doubles as the pending-buffer valid flag, so a full buffer drops new strobes.
    assign capture     = i_mem_wr && !o_wait && ((state != ST_IDLE) || clear_start);
    assign unused_io   = &{1'b0, i_io_data[6:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            fill_attr   <= '0;
            pend_plane  <= 1'b0;
            pend_addr   <= '0;
            pend_data   <= '0;
            o_wait      <= 1'b0;
            o_busy      <= 1'b0;
            o_char_we   <= 1'b0;
            o_attr_we   <= 1'b0;
            o_vram_addr <= '0;
            o_char_data <= '0;
            o_attr_data <= '0;
        end else begin
            o_char_we <= 1'b0;
            o_attr_we <= 1'b0;

            if (i_io_wr && (i_io_addr == PORT_FILL)) begin
                fill_attr <= i_io_data;
            end

            if (capture) begin
                pend_plane <= i_mem_addr[11];
                pend_addr  <= i_mem_addr[10:0];
                pend_data  <= i_mem_data;
                o_wait     <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        // Outputs are registered, so address 0 is presented in the first FILL cycle.
                        state       <= ST_FILL;
                        o_busy      <= 1'b1;
                        o_char_we   <= 1'b1;
                        o_attr_we   <= 1'b1;
                        o_vram_addr <= '0;
                        o_char_data <= BLANK_CHAR;
                        o_attr_data <= fill_attr;
                    end else if (o_wait) begin
                        o_wait      <= 1'b0;
                        o_vram_addr <= pend_addr;
                        o_char_we   <= !pend_plane;
                        o_attr_we   <= pend_plane;
                        if (pend_plane) begin
                            o_attr_data <= pend_data;
                        end else begin
                            o_char_data <= pend_data;
                        end
                    end else if (i_mem_wr) begin
                        o_vram_addr <= i_mem_addr[10:0];
                        o_char_we   <= !i_mem_addr[11];
                        o_attr_we   <= i_mem_addr[11];
                        if (i_mem_addr[11]) begin
                            o_attr_data <= i_mem_data;
                        end else begin
                            o_char_data <= i_mem_data;
                        end
                    end
                end

                ST_FILL: begin
                    if (o_vram_addr != '1) begin
                        o_vram_addr <= o_vram_addr + 11'd1;
                        o_char_we   <= 1'b1;
                        o_attr_we   <= 1'b1;
                    end else if (o_wait) begin
                        state       <= ST_FLUSH;
                        o_wait      <= 1'b0;
                        o_vram_addr <= pend_addr;
                        o_char_we   <= !pend_plane;
                        o_attr_we   <= pend_plane;
                        if (pend_plane) begin
                            o_attr_data <= pend_data;
                        end else begin
                            o_char_data <= pend_data;
                        end
                    end else begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                    end
                end

                ST_FLUSH: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end
`else
    logic unused_io;

    assign unused_io = &{1'b0, i_io_data[7:1]};
    assign o_wait    = 1'b0;
    assign o_busy    = 1'b0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_char_we   <= 1'b0;
            o_attr_we   <= 1'b0;
            o_vram_addr <= '0;
            o_char_data <= '0;
            o_attr_data <= '0;
        end else begin
            o_char_we <= 1'b0;
            o_attr_we <= 1'b0;
            if (i_mem_wr) begin
                o_vram_addr <= i_mem_addr[10:0];
                o_char_we   <= !i_mem_addr[11];
                o_attr_we   <= i_mem_addr[11];
                if (i_mem_addr[11]) begin
                    o_attr_data <= i_mem_data;
                end else begin
                    o_char_data <= i_mem_data;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_vdu_writer.sv
// Testbench for vdu_writer: register/plane-select vector table plus clear-engine sequences.
// Clear-engine sequences build only when VDU_CLEAR_EN is defined; otherwise the disabled-feature sequence runs.
module tb_vdu_writer;

    localparam logic [7:0] PB = 8'hC0;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_io_wr;
    logic [7:0]  i_io_addr;
    logic [7:0]  i_io_data;
    logic        i_mem_wr;
    logic [11:0] i_mem_addr;
    logic [7:0]  i_mem_data;
    logic        o_wait;
    logic        o_busy;
    logic        o_char_we;
    logic        o_attr_we;
    logic [10:0] o_vram_addr;
    logic [7:0]  o_char_data;
    logic [7:0]  o_attr_data;
    logic        o_mode80;
    logic [4:0]  o_counter;
    logic        o_counter_valid;

    int checks = 0;
    int errors = 0;

    vdu_writer #(
        .PORT_BASE (8'hC0),
        .BLANK_CHAR(8'h20)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_io_wr        (i_io_wr),
        .i_io_addr      (i_io_addr),
        .i_io_data      (i_io_data),
        .i_mem_wr       (i_mem_wr),
        .i_mem_addr     (i_mem_addr),
        .i_mem_data     (i_mem_data),
        .o_wait         (o_wait),
        .o_busy         (o_busy),
        .o_char_we      (o_char_we),
        .o_attr_we      (o_attr_we),
        .o_vram_addr    (o_vram_addr),
        .o_char_data    (o_char_data),
        .o_attr_data    (o_attr_data),
        .o_mode80       (o_mode80),
        .o_counter      (o_counter),
        .o_counter_valid(o_counter_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        string       name;
        logic        io_wr;
        logic [7:0]  io_addr;
        logic [7:0]  io_data;
        logic        mem_wr;
        logic [11:0] mem_addr;
        logic [7:0]  mem_data;
        logic [37:0] exp;
    } vec_t;

    vec_t vecs[11];

    function automatic logic [37:0] pack(input logic w, input logic b, input logic cwe,
                                         input logic awe, input logic [10:0] a,
                                         input logic [7:0] cd, input logic [7:0] ad,
                                         input logic m, input logic [4:0] cnt, input logic v);
        return {w, b, cwe, awe, a, cd, ad, m, cnt, v};
    endfunction

    function automatic logic [37:0] outs();
        return pack(o_wait, o_busy, o_char_we, o_attr_we, o_vram_addr, o_char_data,
                    o_attr_data, o_mode80, o_counter, o_counter_valid);
    endfunction

    function automatic vec_t mk(input string n, input logic iw, input logic [7:0] ia,
                                input logic [7:0] id, input logic mw, input logic [11:0] ma,
                                input logic [7:0] md, input logic [37:0] e);
        vec_t r;
        r.name = n; r.io_wr = iw; r.io_addr = ia; r.io_data = id;
        r.mem_wr = mw; r.mem_addr = ma; r.mem_data = md; r.exp = e;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_in();
        i_io_wr  = 1'b0;
        i_mem_wr = 1'b0;
    endtask

    task automatic set_io(input logic [7:0] a, input logic [7:0] d);
        i_io_wr   = 1'b1;
        i_io_addr = a;
        i_io_data = d;
    endtask

    task automatic set_mem(input logic [11:0] a, input logic [7:0] d);
        i_mem_wr   = 1'b1;
        i_mem_addr = a;
        i_mem_data = d;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_io_wr = 1'b0; i_io_addr = '0; i_io_data = '0;
        i_mem_wr = 1'b0; i_mem_addr = '0; i_mem_data = '0;

        //                     wait busy cwe awe addr     cdata  adata  mode cnt    valid
        vecs[0]  = mk("mode_on",       1, PB,       8'h01, 0, 12'h000, 8'h00, pack(0,0,0,0,11'h000,8'h00,8'h00,1,5'd0, 0));
        vecs[1]  = mk("scroll23",      1, PB+8'd1,  8'd23, 0, 12'h000, 8'h00, pack(0,0,0,0,11'h000,8'h00,8'h00,1,5'd23,1));
        vecs[2]  = mk("scroll24_ign",  1, PB+8'd1,  8'd24, 0, 12'h000, 8'h00, pack(0,0,0,0,11'h000,8'h00,8'h00,1,5'd23,0));
        vecs[3]  = mk("char_wr",       0, 8'h00,    8'h00, 1, 12'h005, 8'h41, pack(0,0,1,0,11'h005,8'h41,8'h00,1,5'd23,0));
        vecs[4]  = mk("attr_wr",       0, 8'h00,    8'h00, 1, 12'h805, 8'h5A, pack(0,0,0,1,11'h005,8'h41,8'h5A,1,5'd23,0));
        vecs[5]  = mk("io_mem_same",   1, PB,       8'h00, 1, 12'h7FF, 8'h33, pack(0,0,1,0,11'h7FF,8'h33,8'h5A,0,5'd23,0));
        vecs[6]  = mk("bad_port",      1, PB+8'd3,  8'h01, 0, 12'h000, 8'h00, pack(0,0,0,0,11'h7FF,8'h33,8'h5A,0,5'd23,0));
        vecs[7]  = mk("scroll0",       1, PB+8'd1,  8'd0,  0, 12'h000, 8'h00, pack(0,0,0,0,11'h7FF,8'h33,8'h5A,0,5'd0, 1));
        vecs[8]  = mk("no_strobe",     0, PB+8'd1,  8'd5,  0, 12'h123, 8'h99, pack(0,0,0,0,11'h7FF,8'h33,8'h5A,0,5'd0, 0));
        vecs[9]  = mk("attr_top",      0, 8'h00,    8'h00, 1, 12'hFFF, 8'h77, pack(0,0,0,1,11'h7FF,8'h33,8'h77,0,5'd0, 0));
        vecs[10] = mk("scroll_ff_ign", 1, PB+8'd1,  8'hFF, 0, 12'h000, 8'h00, pack(0,0,0,0,11'h7FF,8'h33,8'h77,0,5'd0, 0));

        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_vals", 64'(outs()), 64'(pack(0,0,0,0,11'h000,8'h00,8'h00,0,5'd0,0)));
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            i_io_wr = vecs[i].io_wr; i_io_addr = vecs[i].io_addr; i_io_data = vecs[i].io_data;
            i_mem_wr = vecs[i].mem_wr; i_mem_addr = vecs[i].mem_addr; i_mem_data = vecs[i].mem_data;
            step();
            idle_in();
            chk(vecs[i].name, 64'(outs()), 64'(vecs[i].exp));
        end

`ifdef VDU_CLEAR_EN
        begin
            int n;
            // Full clear with fill attribute 0C.
            set_io(PB + 8'd2, 8'h0C); step(); idle_in();
            set_io(PB, 8'h80); step(); idle_in();
            n = 0;
            while (o_busy && n < 3000) begin
                if (n < 2048)
                    chk("fill_a", 64'(outs()), 64'(pack(0,1,1,1,11'(n),8'h20,8'h0C,0,5'd0,0)));
                n++;
                step();
            end
            chk("busy_len", 64'(n), 64'd2048);
            chk("fill_a_end", 64'(outs()), 64'(pack(0,0,0,0,11'h7FF,8'h20,8'h0C,0,5'd0,0)));

            // Write during fill, dropped second strobe, ignored restart.
            set_io(PB, 8'h80); step(); idle_in();
            for (int c = 0; c < 2048; c++) begin
                chk("fill_b", 64'(outs()), 64'(pack(c > 100,1,1,1,11'(c),8'h20,8'h0C,0,5'd0,0)));
                if (c == 100) set_mem(12'h123, 8'h99);
                if (c == 101) set_mem(12'h845, 8'h55);
                if (c == 500) set_io(PB, 8'h80);
                step();
                idle_in();
            end
            chk("flush_b", 64'(outs()), 64'(pack(0,1,1,0,11'h123,8'h99,8'h0C,0,5'd0,0)));
            step();
            chk("after_flush_b", 64'(outs()), 64'(pack(0,0,0,0,11'h123,8'h99,8'h0C,0,5'd0,0)));
            for (int c = 0; c < 3; c++) begin
                step();
                chk("no_dropped_wr", 64'(outs()), 64'(pack(0,0,0,0,11'h123,8'h99,8'h0C,0,5'd0,0)));
            end

            // Mid-fill asynchronous reset with a write pending.
            set_io(PB + 8'd1, 8'd7); step(); idle_in();
            set_io(PB, 8'h81); step(); idle_in();
            for (int c = 0; c <= 1000; c++) begin
                chk("fill_c", 64'(outs()), 64'(pack(c > 10,1,1,1,11'(c),8'h20,8'h0C,1,5'd7,0)));
                if (c == 10) set_mem(12'h0AB, 8'h12);
                if (c < 1000) begin
                    step();
                    idle_in();
                end
            end
            #2 i_rst_n = 1'b0;
            #1;
            chk("async_reset", 64'(outs()), 64'(pack(0,0,0,0,11'h000,8'h00,8'h00,0,5'd0,0)));
            #3 i_rst_n = 1'b1;
            for (int c = 0; c < 5; c++) begin
                step();
                chk("post_reset_idle", 64'(outs()), 64'(pack(0,0,0,0,11'h000,8'h00,8'h00,0,5'd0,0)));
            end

            // Fill attribute back at reset value; strobe coincident with clear start is buffered.
            set_io(PB, 8'h80); set_mem(12'h8AA, 8'h66); step(); idle_in();
            for (int c = 0; c < 2048; c++) begin
                chk("fill_d", 64'(outs()), 64'(pack(1,1,1,1,11'(c),8'h20,8'h00,0,5'd0,0)));
                step();
            end
            chk("flush_d", 64'(outs()), 64'(pack(0,1,0,1,11'h0AA,8'h20,8'h66,0,5'd0,0)));
            step();
            chk("after_flush_d", 64'(outs()), 64'(pack(0,0,0,0,11'h0AA,8'h20,8'h66,0,5'd0,0)));
        end
`else
        // Clear feature absent: control bit 7 does nothing, memory writes pass straight through.
        set_io(PB, 8'h80); set_mem(12'h010, 8'h11); step(); idle_in();
        chk("direct_wr", 64'(outs()), 64'(pack(0,0,1,0,11'h010,8'h11,8'h77,0,5'd0,0)));
        for (int c = 0; c < 2100; c++) begin
            step();
            chk("no_clear", 64'(outs()), 64'(pack(0,0,0,0,11'h010,8'h11,8'h77,0,5'd0,0)));
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
